spi_slave_regfile: RTL
======================

// Module: spi_slave_regfile
// PURPOSE
//  SPI responder (CPOL=0, CPHA=0, MSB first) answering 16-bit HDP-style frames: upper byte
//  {rw, addr[6:0]} (rw=1 read, rw=0 write), lower byte data. Holds a local 8-bit register file.
//  Sits on the FPGA slave side / in benches as the HDP-1280-2 register-interface counterpart of
//  our SPI master; SCLK/CS/MOSI are oversampled in the system clock domain.
// PARAMETERS
//  NUM_REGS    16     registers implemented, addresses 0..NUM_REGS-1 (max 128)
//  RESET_VALUE 8'h00  value loaded into every register on reset
//  SYNC_STAGES 2      synchroniser depth on SCLK, CS, MOSI
// PORTS
//  i_clock        in   1  system clock; sole clock
//  i_reset_n      in   1  asynchronous, active-low reset
//  SCLK           in   1  SPI clock from master, idle low
//  CS             in   1  chip select, active low
//  MOSI           in   1  master data out
//  MISO           out  1  slave data out
//  i_rd_addr      in   7  local read-port address
//  o_rd_data      out  8  local read data, registered
//  o_wr_strobe    out  1  1-cycle pulse on committed SPI write
//  o_wr_addr      out  7  address of committed write, held until next commit
//  o_wr_data      out  8  data of committed write, held until next commit
//  o_frame_error  out  1  1-cycle pulse, CS deasserted mid-frame
//  o_busy         out  1  high while a frame is in progress (CS low, synced)
// BEHAVIOUR
//  Reset: MISO=0, o_rd_data=0, o_wr_*=0, o_frame_error=0, o_busy=0, all regs=RESET_VALUE,
//   FSM->WAIT_CS_HIGH.
//  Inputs pass SYNC_STAGES flops; edges detected on synced SCLK/CS. Master SCLK high and low
//   phases must each be >= SYNC_STAGES+3 i_clock cycles; slower is always fine.
//  FSM: WAIT_CS_HIGH -(CS high)-> IDLE -(CS fall)-> ADDR -(8th rise)-> DATA -(16th rise)->
//   DONE -(CS rise)-> IDLE. CS rise in ADDR/DATA -> IDLE + o_frame_error pulse, no write.
//  Bit counter 0..16, cleared on CS fall, saturates at 16; SCLK edges after 16 ignored.
//  MOSI sampled on synced SCLK rise into 16-bit shift reg.
//  MISO updated on synced SCLK fall (and on CS fall for bit 0): upper-byte bits drive 0.
//   At 8th rise: rw/addr latched, read data fetched from regfile (0x00 if addr>=NUM_REGS or
//   rw=0); MSB driven on 8th fall, remaining bits on following falls. MISO=0 in IDLE/DONE.
//  Write commit: on 16th rise with rw=0 and addr<NUM_REGS: reg written, o_wr_strobe high next
//   cycle, o_wr_addr/o_wr_data updated same cycle as strobe. addr>=NUM_REGS: no write, no strobe.
//  Local port: o_rd_data = reg[i_rd_addr] registered, 1-cycle latency; 0x00 if out of range.
//   Read and SPI write to same reg in same cycle: o_rd_data returns old value (read-first).
//  o_busy = state in {ADDR,DATA,DONE}.
//  Reset asserted mid-frame: immediate return to reset values; no partial write; frame in
//   flight ignored until CS seen high (WAIT_CS_HIGH), even if reset releases while CS low.
// TESTING
//  SPI write 0x05<-0xA5 -> o_wr_strobe one cycle, o_wr_addr=0x05, o_wr_data=0xA5; i_rd_addr=5 -> 0xA5.
//  SPI read 0x85 after above -> master Rx_Upper=0x00, Rx_Lower=0xA5; register unchanged.
//  CS raised after 10 SCLKs of write 0x03<-0x3C -> o_frame_error pulse, reg 3 = RESET_VALUE, no strobe.
//  Write 0x7F<-0x11 and read 0xFF (NUM_REGS=16) -> no strobe, Rx_Lower=0x00.
//  Reset mid-frame (bit 9), release with CS low -> MISO=0, no strobe; next full frame after CS high works.
//  Two back-to-back writes, CS high one SCLK period between -> two strobes, both values stored;
//   18 SCLKs in one frame -> single write, extra edges ignored.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// ============================================================================
// Module  : spi_slave_regfile
// Brief   : Oversampled SPI responder (mode 0, MSB first) serving 16-bit
//           {rw, addr[6:0], data[7:0]} frames against a local 8-bit regfile.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_slave_regfile #(
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] RESET_VALUE = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       SCLK,
  input  logic       CS,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [6:0] i_rd_addr,
  output logic [7:0] o_rd_data,
  output logic       o_wr_strobe,
  output logic [6:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_frame_error,
  output logic       o_busy
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [2:0] {
    S_WAIT_CS_HIGH = 3'd0,
    S_IDLE         = 3'd1,
    S_ADDR         = 3'd2,
    S_DATA         = 3'd3,
    S_DONE         = 3'd4
  } state_t;

  function automatic logic in_range(input logic [6:0] a);
    return (32'(a) < NUM_REGS);
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;

  // CS synchroniser resets low so a frame already in flight at reset release
  // is never mistaken for an idle bus.
  generate
    if (SYNC_STAGES == 1) begin : g_sync_single
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          sclk_sync_q <= '0;
          cs_sync_q   <= '0;
          mosi_sync_q <= '0;
        end else begin
          sclk_sync_q <= SCLK;
          cs_sync_q   <= CS;
          mosi_sync_q <= MOSI;
        end
      end
    end else begin : g_sync_chain
      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          sclk_sync_q <= '0;
          cs_sync_q   <= '0;
          mosi_sync_q <= '0;
        end else begin
          sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
          cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
          mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        end
      end
    end
  endgenerate

  logic sclk_s, cs_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign cs_rise   =  cs_s   & ~cs_prev_q;
  assign cs_fall   = ~cs_s   &  cs_prev_q;

  state_t     state_q;
  logic [4:0] bit_cnt_q;
  logic [6:0] shift_q;   // trailing 7 received bits; the live MOSI bit completes a byte
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] tx_q;
  logic [7:0] regs_q [NUM_REGS];

  logic [6:0] addr_d;
  logic [7:0] wdata_d;
  assign addr_d  = {shift_q[5:0], mosi_s};
  assign wdata_d = {shift_q[6:0], mosi_s};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b0;
      state_q       <= S_WAIT_CS_HIGH;
      bit_cnt_q     <= 5'd0;
      shift_q       <= 7'd0;
      rw_q          <= 1'b0;
      addr_q        <= 7'd0;
      tx_q          <= 8'h00;
      MISO          <= 1'b0;
      o_wr_strobe   <= 1'b0;
      o_wr_addr     <= 7'd0;
      o_wr_data     <= 8'h00;
      o_frame_error <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      sclk_prev_q   <= sclk_s;
      cs_prev_q     <= cs_s;
      o_wr_strobe   <= 1'b0;
      o_frame_error <= 1'b0;
      case (state_q)
        S_WAIT_CS_HIGH: begin
          MISO <= 1'b0;
          if (cs_s) state_q <= S_IDLE;
        end
        S_IDLE: begin
          MISO <= 1'b0;
          if (cs_fall) begin
            state_q   <= S_ADDR;
            bit_cnt_q <= 5'd0;
            shift_q   <= 7'd0;
          end
        end
        S_ADDR, S_DATA: begin
          if (cs_rise) begin
            state_q       <= S_IDLE;
            MISO          <= 1'b0;
            o_frame_error <= 1'b1;
          end else if (sclk_rise) begin
            shift_q   <= {shift_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              state_q <= S_DATA;
              rw_q    <= shift_q[6];
              addr_q  <= addr_d;
              tx_q    <= (shift_q[6] && in_range(addr_d)) ? regs_q[addr_d[AW-1:0]] : 8'h00;
            end
            if (bit_cnt_q == 5'd15) begin
              state_q <= S_DONE;
              MISO    <= 1'b0;
              if (!rw_q && in_range(addr_q)) begin
                regs_q[addr_q[AW-1:0]] <= wdata_d;
                o_wr_strobe            <= 1'b1;
                o_wr_addr              <= addr_q;
                o_wr_data              <= wdata_d;
              end
            end
          end else if (sclk_fall) begin
            if (state_q == S_DATA) begin
              MISO <= tx_q[7];
              tx_q <= {tx_q[6:0], 1'b0};
            end else begin
              MISO <= 1'b0;
            end
          end
        end
        S_DONE: begin
          MISO <= 1'b0;
          if (cs_rise) state_q <= S_IDLE;
        end
        default: state_q <= S_WAIT_CS_HIGH;
      endcase
    end
  end

  // Plain registered read: a same-cycle SPI write lands after this sample.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rd_data <= 8'h00;
    end else begin
      o_rd_data <= in_range(i_rd_addr) ? regs_q[i_rd_addr[AW-1:0]] : 8'h00;
    end
  end

  assign o_busy = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_DONE);

endmodule

`default_nettype wire
